riscv_multi_cycle: RTL

Multi-cycle RV32I-subset core. It is the successor to the single-cycle top and replaces the split instruction/data memories with one shared memory port that uses a valid/ready handshake. A control FSM sequences each instruction over several cycles and stalls on memory wait states. Branch and jump support, a retire strobe and a halt-on-illegal mechanism are added. The core sits between the system memory/bus and the debug/testbench logic.

---
 rtl/riscv_multi_cycle.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_multi_cycle.sv
// rtl/riscv_multi_cycle.sv - multi-cycle RV32I-subset core with a shared valid/ready memory port
module riscv_multi_cycle #(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter bit          HALT_ON_MISALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        instr_retired,
    output logic        halted,
    output logic [31:0] pc_dbg
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEMADR, S_MEMRD,
        S_MEMWR, S_ALUWB, S_MEMWB, S_BRANCH, S_JAL, S_HALT
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_pc;
    logic [31:0] r_old_pc;
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_imm;
    logic [31:0] r_alu_out;
    logic [31:0] r_mdr;
    logic [31:0] r_regs [0:31];

    // Instruction fields
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;

    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[11:7];
    assign w_funct3 = r_ir[14:12];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_funct7 = r_ir[31:25];

    // Immediates, all sign-extended from instruction bit 31
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;

    assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

    // Legal-encoding decode; anything not matched here halts the core
    logic w_alu_f3_ok;
    logic w_is_r;
    logic w_is_i;
    logic w_is_lw;
    logic w_is_sw;
    logic w_is_br;
    logic w_is_jal;

    assign w_alu_f3_ok = (w_funct3 == 3'b000) || (w_funct3 == 3'b111) ||
                         (w_funct3 == 3'b110) || (w_funct3 == 3'b010);
    assign w_is_r   = (w_opcode == OP_R) &&
                      (((w_funct7 == 7'b0000000) && w_alu_f3_ok) ||
                       ((w_funct7 == 7'b0100000) && (w_funct3 == 3'b000)));
    assign w_is_i   = (w_opcode == OP_I) && w_alu_f3_ok;
    assign w_is_lw  = (w_opcode == OP_LD) && (w_funct3 == 3'b010);
    assign w_is_sw  = (w_opcode == OP_ST) && (w_funct3 == 3'b010);
    assign w_is_br  = (w_opcode == OP_BR) && (w_funct3[2:1] == 2'b00);
    assign w_is_jal = (w_opcode == OP_JAL);

    // Register-file read ports; x0 always reads zero
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;

    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];

    // ALU, address generation, branch compare and PC targets
    logic [31:0] w_alu_b;
    logic        w_alu_sub;
    logic [31:0] w_alu_result;
    logic [31:0] w_agen;
    logic        w_agen_misalign;
    logic        w_fetch_misalign;
    logic        w_br_taken;
    logic [31:0] w_target;
    logic [31:0] w_link;
    logic [31:0] w_imm_sel;

    assign w_alu_b          = (r_state == S_EXEC_R) ? r_b : r_imm;
    assign w_alu_sub        = (r_state == S_EXEC_R) && r_ir[30];
    assign w_agen           = r_a + r_imm;
    assign w_agen_misalign  = HALT_ON_MISALIGN && (w_agen[1:0] != 2'b00);
    assign w_fetch_misalign = HALT_ON_MISALIGN && (r_pc[1:0] != 2'b00);
    assign w_br_taken       = w_funct3[0] ? (r_a != r_b) : (r_a == r_b);
    assign w_target         = r_old_pc + r_imm;
    assign w_link           = r_old_pc + 32'd4;

    // ALU operation selected by funct3; bit 30 picks sub only for R-type
    always_comb begin
        w_alu_result = r_a + w_alu_b;
        case (w_funct3)
            3'b000:  w_alu_result = w_alu_sub ? (r_a - w_alu_b) : (r_a + w_alu_b);
            3'b111:  w_alu_result = r_a & w_alu_b;
            3'b110:  w_alu_result = r_a | w_alu_b;
            3'b010:  w_alu_result = {31'd0, $signed(r_a) < $signed(w_alu_b)};
            default: w_alu_result = r_a + w_alu_b;
        endcase
    end

    // Immediate format chosen by opcode while decoding
    always_comb begin
        w_imm_sel = w_imm_i;
        case (w_opcode)
            OP_ST:   w_imm_sel = w_imm_s;
            OP_BR:   w_imm_sel = w_imm_b;
            OP_JAL:  w_imm_sel = w_imm_j;
            default: w_imm_sel = w_imm_i;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; memory states hold until mem_ready
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_fetch_misalign) begin
                    w_next_state = S_HALT;
                end else if (mem_ready) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_is_r)                    w_next_state = S_EXEC_R;
                else if (w_is_i)               w_next_state = S_EXEC_I;
                else if (w_is_lw || w_is_sw)   w_next_state = S_MEMADR;
                else if (w_is_br)              w_next_state = S_BRANCH;
                else if (w_is_jal)             w_next_state = S_JAL;
                else                           w_next_state = S_HALT;
            end
            S_EXEC_R, S_EXEC_I: w_next_state = S_ALUWB;
            S_MEMADR: begin
                if (w_agen_misalign)   w_next_state = S_HALT;
                else if (w_is_lw)      w_next_state = S_MEMRD;
                else                   w_next_state = S_MEMWR;
            end
            S_MEMRD:  if (mem_ready) w_next_state = S_MEMWB;
            S_MEMWR:  if (mem_ready) w_next_state = S_FETCH;
            S_ALUWB, S_MEMWB, S_BRANCH, S_JAL: w_next_state = S_FETCH;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_HALT;
        endcase
    end

    // FSM outputs: memory request, retire strobe and register write control
    logic        w_req;
    logic [31:0] w_req_addr;
    logic        w_rf_we;
    logic [31:0] w_rf_wdata;

    always_comb begin
        w_req         = 1'b0;
        w_req_addr    = r_alu_out;
        w_rf_we       = 1'b0;
        w_rf_wdata    = r_alu_out;
        instr_retired = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_req      = !w_fetch_misalign;
                w_req_addr = r_pc;
            end
            S_MEMRD:  w_req = 1'b1;
            S_MEMWR: begin
                w_req         = 1'b1;
                instr_retired = mem_ready;
            end
            S_ALUWB: begin
                w_rf_we       = 1'b1;
                instr_retired = 1'b1;
            end
            S_MEMWB: begin
                w_rf_we       = 1'b1;
                w_rf_wdata    = r_mdr;
                instr_retired = 1'b1;
            end
            S_BRANCH: instr_retired = 1'b1;
            S_JAL: begin
                w_rf_we       = 1'b1;
                w_rf_wdata    = w_link;
                instr_retired = 1'b1;
            end
            default: ;
        endcase
        // Reset suppresses requests and retirement; x0 never takes a write
        if (rst) begin
            w_req         = 1'b0;
            instr_retired = 1'b0;
        end
        w_rf_we   = w_rf_we && (w_rd != 5'd0);
        mem_valid = w_req;
        mem_we    = w_req && (r_state == S_MEMWR);
        mem_addr  = w_req ? {w_req_addr[31:2], 2'b00} : 32'd0;
        mem_wdata = (w_req && (r_state == S_MEMWR)) ? r_b : 32'd0;
        halted    = (r_state == S_HALT);
    end

    assign pc_dbg = r_pc;

    // Datapath registers and register file, updated per FSM state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_old_pc  <= 32'd0;
            r_ir      <= 32'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_imm     <= 32'd0;
            r_alu_out <= 32'd0;
            r_mdr     <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (!w_fetch_misalign && mem_ready) begin
                        r_ir     <= mem_rdata;
                        r_old_pc <= r_pc;
                        r_pc     <= r_pc + 32'd4;
                    end
                end
                S_DECODE: begin
                    r_a   <= w_rs1_val;
                    r_b   <= w_rs2_val;
                    r_imm <= w_imm_sel;
                end
                S_EXEC_R, S_EXEC_I: r_alu_out <= w_alu_result;
                S_MEMADR: r_alu_out <= w_agen;
                S_MEMRD:  if (mem_ready) r_mdr <= mem_rdata;
                S_BRANCH: if (w_br_taken) r_pc <= w_target;
                S_JAL:    r_pc <= w_target;
                default: ;
            endcase
            if (w_rf_we) begin
                r_regs[w_rd] <= w_rf_wdata;
            end
        end
    end

endmodule
